// File: rtl/alu_arbiter.sv
// alu_arbiter
// -----------
// Two requesters share one ALU. A round-robin arbiter picks one requester per
// accept. The chosen operation goes through the ALU in the accept cycle. Its
// result is then held in an output register until the consumer takes it.
//
// Configuration macro: ALU_ARBITER_DIVZERO_EN
//   defined   : a divide with a zero divisor registers all ones and sets
//               resp_divzero.
//   undefined : the ALU output is registered unchanged for every op, and
//               resp_divzero is tied to 0.
//
// Ports
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   req0_valid/ready/a/b/op   requester 0 (op: 00 add, 01 sub, 10 mul, 11 div)
//   req1_valid/ready/a/b/op   requester 1
//   resp_valid/ready          result handshake toward the consumer
//   resp_id                   index of the requester that owns the result
//   resp_result               registered ALU result (XLEN bits)
//   resp_divzero              result came from a divide by zero (macro only)
//   state_dbg                 current FSM state (0 = IDLE, 1 = RESP)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. A producer that raises valid keeps its payload stable until ready.
// reqN_ready is combinational from the request valids, the FSM state and
// resp_ready. It never depends on itself.

module alu
#(
    parameter int XLEN = 64
)
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [1:0]      op,
    output logic [XLEN-1:0] y
);
    always_comb begin
        y = '0;
        case (op)
            2'b00: y = a + b;
            2'b01: y = a - b;
            2'b10: y = a * b;          // low XLEN bits of the product
            // Unsigned divide. A zero divisor yields 0, so the output is
            // always a defined value.
            default: y = (b == '0) ? '0 : (a / b);
        endcase
    end
endmodule

module alu_arbiter
#(
    parameter int XLEN = 64
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  logic [1:0]      req0_op,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    input  logic [1:0]      req1_op,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic            resp_id,
    output logic [XLEN-1:0] resp_result,
    output logic            resp_divzero,
    output logic            state_dbg
);
    typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

    state_t          state;
    logic            rr_last;      // index granted at the most recent accept
    logic            accept_ok;
    logic            gnt_valid;
    logic            gnt_id;
    logic [XLEN-1:0] gnt_a;
    logic [XLEN-1:0] gnt_b;
    logic [1:0]      gnt_op;
    logic [XLEN-1:0] alu_y;
    logic [XLEN-1:0] next_result;
    logic            next_divzero;

    // The output register is free when it is empty, or when it is being
    // drained on this same edge. Reset blocks all accepts.
    assign accept_ok = ((state == IDLE) | resp_ready) & ~rst;
    assign gnt_valid = accept_ok & (req0_valid | req1_valid);

    // Under contention, grant the requester that was not served last.
    // Otherwise grant whichever requester is valid.
    always_comb begin
        gnt_id = 1'b0;
        if (req0_valid && req1_valid) gnt_id = ~rr_last;
        else if (req1_valid)          gnt_id = 1'b1;
    end

    assign req0_ready = gnt_valid & ~gnt_id;
    assign req1_ready = gnt_valid &  gnt_id;

    assign gnt_a  = gnt_id ? req1_a  : req0_a;
    assign gnt_b  = gnt_id ? req1_b  : req0_b;
    assign gnt_op = gnt_id ? req1_op : req0_op;

    alu #(.XLEN(XLEN)) u_alu (
        .a  (gnt_a),
        .b  (gnt_b),
        .op (gnt_op),
        .y  (alu_y)
    );

`ifdef ALU_ARBITER_DIVZERO_EN
    // A zero-divisor divide bypasses the quotient entirely.
    assign next_divzero = (gnt_op == 2'b11) && (gnt_b == '0);
    assign next_result  = next_divzero ? '1 : alu_y;
`else
    assign next_divzero = 1'b0;
    assign next_result  = alu_y;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            resp_result <= '0;
            resp_id     <= 1'b0;
            rr_last     <= 1'b1;       // req0 wins the first contention
        end else begin
            if (gnt_valid) begin
                // The accept either fills an empty register or replaces a
                // result that is delivered on this same edge.
                state       <= RESP;
                resp_result <= next_result;
                resp_id     <= gnt_id;
                rr_last     <= gnt_id;
            end else if ((state == RESP) && resp_ready) begin
                state <= IDLE;
            end
        end
    end

`ifdef ALU_ARBITER_DIVZERO_EN
    logic divzero_q;
    always_ff @(posedge clk) begin
        if (rst)            divzero_q <= 1'b0;
        else if (gnt_valid) divzero_q <= next_divzero;
    end
    assign resp_divzero = divzero_q;
`else
    assign resp_divzero = next_divzero;
`endif

    assign resp_valid = (state == RESP);
    assign state_dbg  = state;
endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  localparam int XLEN = 64;
  localparam int W    = XLEN + 2;   // {id, divzero, result}

  logic            clk = 1'b0;
  logic            rst;
  logic            req0_valid, req0_ready, req1_valid, req1_ready;
  logic [XLEN-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]      req0_op, req1_op;
  logic            resp_valid, resp_ready, resp_id, resp_divzero, state_dbg;
  logic [XLEN-1:0] resp_result;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mask_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  alu_arbiter #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_result(resp_result),
    .resp_divzero(resp_divzero), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(input logic id, input logic dz, input logic [XLEN-1:0] r);
    return {id, dz, r};
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor / scoreboard: every cycle with resp_valid, the output must match
  // the oldest outstanding expectation; it retires when the consumer takes it.
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", {resp_id, resp_divzero, resp_result}, '0);
      end else begin
        chk("resp", {resp_id, resp_divzero, resp_result} & mask_q[0], exp_q[0] & mask_q[0]);
        if (resp_ready === 1'b1) begin
          void'(exp_q.pop_front());
          void'(mask_q.pop_front());
        end
      end
    end
  end

  // driver tasks
  task automatic set0(input logic v, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic [1:0] op);
    req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
  endtask

  task automatic set1(input logic v, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic [1:0] op);
    req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
  endtask

  // One cycle: check the expected grant and resp_valid, then queue the
  // expected result if something is accepted.
  task automatic step(input logic eg0, input logic eg1, input logic ev,
                      input logic [W-1:0] e, input logic [W-1:0] m);
    @(negedge clk);
    chk("grant", {req0_ready, req1_ready}, {eg0, eg1});
    chk("resp_valid", resp_valid, ev);
    if (eg0 | eg1) begin
      exp_q.push_back(e);
      mask_q.push_back(m);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; resp_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("ready_in_reset", {req0_ready, req1_ready}, 2'b00);
      @(posedge clk); #1;
      exp_q.delete();
      mask_q.delete();
    end
    rst = 1'b0; resp_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("after_reset", {resp_valid, resp_id, resp_divzero, resp_result}, '0);
  endtask

  localparam logic [W-1:0] ALL = '1;
  localparam logic [W-1:0] X = '0;

  logic [W-1:0] div0_e, div0_m;

  initial begin
    rst = 1'b1; resp_ready = 1'b1;
    set0(1'b0, '0, '0, 2'b00);
    set1(1'b0, '0, '0, 2'b00);
    @(posedge clk); #1;
    do_reset();

    // single add, 1-cycle latency
    set0(1'b1, 64'd5, 64'd7, 2'b00);
    step(1, 0, 0, mk(0, 0, 64'd12), ALL);
    set0(1'b0, '0, '0, 2'b00);
    step(0, 0, 1, X, X);
    step(0, 0, 0, X, X);

    // contention on the first cycle after reset: req0 first
    do_reset();
    set0(1'b1, 64'd3, 64'd5, 2'b01);
    set1(1'b1, 64'h2_0000_0000, 64'h1_0000_0000, 2'b10);
    step(1, 0, 0, mk(0, 0, 64'hFFFF_FFFF_FFFF_FFFE), ALL);
    req0_valid = 1'b0;
    step(0, 1, 1, mk(1, 0, 64'd0), ALL);
    req1_valid = 1'b0;
    step(0, 0, 1, X, X);

    // continuous contention alternates, one result per cycle
    set0(1'b1, 64'd10, 64'd1, 2'b00);
    set1(1'b1, 64'd10, 64'd1, 2'b01);
    step(1, 0, 0, mk(0, 0, 64'd11), ALL);
    step(0, 1, 1, mk(1, 0, 64'd9), ALL);
    step(1, 0, 1, mk(0, 0, 64'd11), ALL);
    step(0, 1, 1, mk(1, 0, 64'd9), ALL);
    req0_valid = 1'b0; req1_valid = 1'b0;
    step(0, 0, 1, X, X);
    step(0, 0, 0, X, X);

    // consumer stall: result held, no accepts, then resume
    set0(1'b1, 64'd1, 64'd2, 2'b00);
    step(1, 0, 0, mk(0, 0, 64'd3), ALL);
    resp_ready = 1'b0;
    set0(1'b1, 64'd4, 64'd4, 2'b00);
    set1(1'b1, 64'd3, 64'd5, 2'b10);
    for (int i = 0; i < 3; i++) step(0, 0, 1, X, X);
    resp_ready = 1'b1;
    step(0, 1, 1, mk(1, 0, 64'd15), ALL);
    req1_valid = 1'b0;
    step(1, 0, 1, mk(0, 0, 64'd8), ALL);
    req0_valid = 1'b0;
    step(0, 0, 1, X, X);
    step(0, 0, 0, X, X);

    // divide by zero, then an ordinary divide
`ifdef ALU_ARBITER_DIVZERO_EN
    div0_e = mk(1, 1, '1); div0_m = ALL;
`else
    div0_e = mk(1, 0, '0); div0_m = {2'b11, {XLEN{1'b0}}};
`endif
    set1(1'b1, 64'd100, 64'd0, 2'b11);
    step(0, 1, 0, div0_e, div0_m);
    set1(1'b1, 64'd100, 64'd7, 2'b11);
    step(0, 1, 1, mk(1, 0, 64'd14), ALL);
    req1_valid = 1'b0;
    step(0, 0, 1, X, X);
    step(0, 0, 0, X, X);

    // reset while a result is held: it is dropped, and req0 wins next
    set0(1'b1, 64'd1, 64'd1, 2'b00);
    step(1, 0, 0, mk(0, 0, 64'd2), ALL);
    do_reset();
    set0(1'b1, 64'd2, 64'd2, 2'b00);
    set1(1'b1, 64'd9, 64'd9, 2'b00);
    step(1, 0, 0, mk(0, 0, 64'd4), ALL);
    req0_valid = 1'b0;
    step(0, 1, 1, mk(1, 0, 64'd18), ALL);
    req1_valid = 1'b0;
    step(0, 0, 1, X, X);
    step(0, 0, 0, X, X);

    // final report
    chk("queue_drained", exp_q.size(), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
